// File: rtl/lii_out_arbiter_if.sv
// rtl/lii_out_arbiter_if.sv - LII requester/phy handshake bundle for lii_out_arbiter
interface lii_out_arbiter_if #(
    parameter int NREQ = 4,
    parameter int PW   = 64
);
    logic [NREQ*PW-1:0] req_tdata;
    logic [NREQ-1:0]    req_tvalid;
    logic [NREQ-1:0]    req_tready;
    logic [NREQ*8-1:0]  req_src;
    logic [NREQ*8-1:0]  req_dst;
    logic [PW-1:0]      out_tdata;
    logic               out_tvalid;
    logic               out_tready;
    logic [7:0]         out_src;
    logic [7:0]         out_dst;

    // requester/phy side
    modport master (
        output req_tdata, req_tvalid, req_src, req_dst, out_tready,
        input  req_tready, out_tdata, out_tvalid, out_src, out_dst
    );

    // arbiter side
    modport slave (
        input  req_tdata, req_tvalid, req_src, req_dst, out_tready,
        output req_tready, out_tdata, out_tvalid, out_src, out_dst
    );
endinterface

// File: rtl/lii_out_arbiter.sv
// rtl/lii_out_arbiter.sv - burst-locked round-robin LII output arbiter (optional LII_OUT_ARBITER_STATS_EN)
module lii_out_arbiter #(
    parameter int NREQ      = 4,
    parameter int PW        = 64,
    parameter int MAX_BURST = 16
) (
    input  logic                    aclk,
    input  logic                    arstn,
    lii_out_arbiter_if.slave        bus,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
`ifdef LII_OUT_ARBITER_STATS_EN
    ,
    output logic [NREQ*32-1:0]      stat_beats
`endif
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     tag_src_q, tag_src_d;
    logic [7:0]     tag_dst_q, tag_dst_d;
    logic [PW-1:0]  odata_q, odata_d;
    logic [7:0]     osrc_q, osrc_d;
    logic [7:0]     odst_q, odst_d;
    logic           ovalid_q, ovalid_d;

    logic [GW-1:0]  idx;
    logic [GW-1:0]  pick;
    logic           pick_any;
    logic [PW-1:0]  g_data;
    logic [7:0]     g_src, g_dst;
    logic           g_valid;
    logic           ld, tag_match, accept;
    logic [NREQ-1:0] tready;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        idx      = '0;
        pick     = '0;
        pick_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_any && bus.req_tvalid[idx]) begin
                pick_any = 1'b1;
                pick     = idx;
            end
        end
    end

    // granted requester's beat, the tag check and the per-requester ready
    always_comb begin
        g_data    = bus.req_tdata[grant_q*PW +: PW];
        g_src     = bus.req_src[grant_q*8 +: 8];
        g_dst     = bus.req_dst[grant_q*8 +: 8];
        g_valid   = bus.req_tvalid[grant_q];
        ld        = ~ovalid_q | bus.out_tready;
        tag_match = (g_src == tag_src_q) && (g_dst == tag_dst_q);
        accept    = (state_q == ST_GRANT) && ld && tag_match && g_valid;
        tready    = '0;
        if (state_q == ST_GRANT) begin
            tready[grant_q] = ld & tag_match;
        end
    end

    // arbitration FSM next state and output-stage next value
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        tag_src_d = tag_src_q;
        tag_dst_d = tag_dst_q;
        ovalid_d  = ovalid_q;
        odata_d   = odata_q;
        osrc_d    = osrc_q;
        odst_d    = odst_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d   = ST_GRANT;
                    grant_d   = pick;
                    tag_src_d = bus.req_src[pick*8 +: 8];
                    tag_dst_d = bus.req_dst[pick*8 +: 8];
                    cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                // a stalled phy freezes the grant; release rules only apply when ld is high
                if (ld) begin
                    if (accept && cnt_q != CW'(MAX_BURST - 1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        if (accept) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ld) begin
            ovalid_d = accept;
            if (accept) begin
                odata_d = g_data;
                osrc_d  = g_src;
                odst_d  = g_dst;
            end
        end
    end

    // state and output registers
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            tag_src_q <= '0;
            tag_dst_q <= '0;
            ovalid_q  <= 1'b0;
            odata_q   <= '0;
            osrc_q    <= '0;
            odst_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            tag_src_q <= tag_src_d;
            tag_dst_q <= tag_dst_d;
            ovalid_q  <= ovalid_d;
            odata_q   <= odata_d;
            osrc_q    <= osrc_d;
            odst_q    <= odst_d;
        end
    end

    assign bus.req_tready = tready;
    assign bus.out_tdata  = odata_q;
    assign bus.out_tvalid = ovalid_q;
    assign bus.out_src    = osrc_q;
    assign bus.out_dst    = odst_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == ST_GRANT);

`ifdef LII_OUT_ARBITER_STATS_EN
    logic [31:0] stat_q [NREQ];

    // per-requester accepted-beat counters, wrapping at 2^32
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (accept) begin
            stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
        end
    end

    // flatten counters onto the port
    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_beats[i*32 +: 32] = stat_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_lii_out_arbiter.sv
// tb/tb_lii_out_arbiter.sv - self-checking bench for lii_out_arbiter
module tb_lii_out_arbiter;
    localparam int NREQ = 4;
    localparam int PW   = 64;
    localparam int MB   = 4;
    localparam int BIG  = 1 << 30;

    logic aclk  = 1'b0;
    logic arstn = 1'b0;
    always #5 aclk = ~aclk;

    lii_out_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus ();
    logic [1:0] grant_id;
    logic       busy;
`ifdef LII_OUT_ARBITER_STATS_EN
    logic [NREQ*32-1:0] stat_beats;
`endif

    lii_out_arbiter #(.NREQ(NREQ), .PW(PW), .MAX_BURST(MB)) dut (
        .aclk     (aclk),
        .arstn    (arstn),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef LII_OUT_ARBITER_STATS_EN
        ,
        .stat_beats (stat_beats)
`endif
    );

    logic [PW-1:0] d_data [NREQ];
    logic          d_vld  [NREQ];
    logic [7:0]    d_src  [NREQ];
    logic [7:0]    d_dst  [NREQ];
    logic          d_otr;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
        assign bus.req_tdata[gi*PW +: PW] = d_data[gi];
        assign bus.req_tvalid[gi]         = d_vld[gi];
        assign bus.req_src[gi*8 +: 8]     = d_src[gi];
        assign bus.req_dst[gi*8 +: 8]     = d_dst[gi];
    end
    assign bus.out_tready = d_otr;

    int          rem [NREQ];
    int          seq [NREQ];
    int          sw  [NREQ];
    logic [7:0]  s_base [NREQ];
    logic [7:0]  d_base [NREQ];
    logic [7:0]  d_alt  [NREQ];
    logic [31:0] salt   [NREQ];
    bit          rv     [NREQ];
    bit          rnd_mode;

    bit          m_busy, m_ov;
    int          m_g, m_rr, m_cnt;
    logic [7:0]  m_ts, m_td, m_os, m_od;
    logic [PW-1:0] m_odata;
    int          m_stat [NREQ];

    typedef struct {
        logic [PW-1:0] d;
        logic [7:0]    s;
        logic [7:0]    t;
        int            cyc;
    } beat_t;
    beat_t olog [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int first_ov = -1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void refresh();
        for (int i = 0; i < NREQ; i++) begin
            d_vld[i]  = rnd_mode ? rv[i] : (rem[i] > 0);
            d_src[i]  = s_base[i];
            d_dst[i]  = (seq[i] >= sw[i]) ? d_alt[i] : d_base[i];
            d_data[i] = {8'(i), 24'(seq[i]), salt[i]};
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_ov = 0; m_g = 0; m_rr = 0; m_cnt = 0;
        m_ts = '0; m_td = '0; m_os = '0; m_od = '0; m_odata = '0;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    endfunction

    function automatic bit m_ld();
        return !m_ov || d_otr;
    endfunction

    function automatic bit m_match();
        return (d_src[m_g] == m_ts) && (d_dst[m_g] == m_td);
    endfunction

    // one clock of the reference: who holds the link and what the phy register shows
    function automatic void model_step();
        bit ld;
        bit acc;
        int g;
        ld = m_ld();
        if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && d_vld[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            end
            if (ld) m_ov = 0;
            if (g >= 0) begin
                m_busy = 1; m_g = g; m_ts = d_src[g]; m_td = d_dst[g]; m_cnt = 0;
            end
        end else begin
            acc = ld && d_vld[m_g] && m_match();
            if (ld) begin
                m_ov = acc;
                if (acc) begin
                    m_odata = d_data[m_g]; m_os = d_src[m_g]; m_od = d_dst[m_g];
                    m_cnt++;
                    m_stat[m_g]++;
                end
                if (!acc || m_cnt == MB) begin
                    m_busy = 0;
                    m_rr   = (m_g + 1) % NREQ;
                end
            end
        end
    endfunction

    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] hs;
        #1;
        exp_rdy = '0;
        if (m_busy && m_ld() && m_match()) exp_rdy[m_g] = 1'b1;
        chk("req_tready", 64'(bus.req_tready), 64'(exp_rdy));
        for (int i = 0; i < NREQ; i++) hs[i] = bus.req_tready[i] & d_vld[i];
        if (bus.out_tvalid && d_otr) olog.push_back('{bus.out_tdata, bus.out_src, bus.out_dst, cyc});
        @(posedge aclk);
        model_step();
        cyc++;
        @(negedge aclk);
        chk("out_tvalid", 64'(bus.out_tvalid), 64'(m_ov));
        if (m_ov) begin
            chk("out_tdata", 64'(bus.out_tdata), 64'(m_odata));
            chk("out_tags", 64'({bus.out_src, bus.out_dst}), 64'({m_os, m_od}));
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_g));
        if (first_ov < 0 && bus.out_tvalid) first_ov = cyc;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                seq[i]++;
                if (rem[i] > 0) rem[i]--;
                if (rnd_mode) begin
                    salt[i] = $urandom;
                    if ($urandom_range(0, 3) == 0) begin
                        s_base[i] = 8'($urandom_range(0, 1));
                        d_base[i] = 8'($urandom_range(0, 1));
                    end
                end
            end
        end
        refresh();
    endtask

    task automatic rnd_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (rv[i] && $urandom_range(0, 7) == 0) begin
                rv[i]   = 0;
                salt[i] = $urandom;
            end else if (!rv[i] && $urandom_range(0, 1) == 1) begin
                rv[i] = 1;
            end
        end
        d_otr = ($urandom_range(0, 3) != 0);
        refresh();
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        d_otr = 1'b1;
        refresh();
        repeat (6) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int errs;
        int pat [4];
        pat = '{1, 0, 0, 1};
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; seq[i] = 0; sw[i] = BIG; s_base[i] = '0; d_base[i] = '0;
            d_alt[i] = '0; salt[i] = '0; rv[i] = 0;
        end
        rnd_mode = 0;
        d_otr    = 1'b1;
        refresh();
        model_reset();
        repeat (2) @(negedge aclk);
        chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        chk("rst_out_tdata", 64'(bus.out_tdata), 64'd0);
        chk("rst_out_tags", 64'({bus.out_src, bus.out_dst}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_req_tready", 64'(bus.req_tready), 64'd0);
        arstn = 1'b1;

        // single requester, five beats
        s_base[2] = 8'h12; d_base[2] = 8'h34; seq[2] = 0; rem[2] = 5;
        refresh();
        olog.delete();
        first_ov = -1;
        t0 = cyc;
        for (int n = 0; n < 60 && olog.size() < 5; n++) tick();
        chk("t1_count", 64'(olog.size()), 64'd5);
        chk("t1_latency", 64'(first_ov - t0), 64'd2);
        for (int k = 0; k < olog.size() && k < 5; k++) begin
            chk("t1_data", 64'(olog[k].d), {8'd2, 24'(k), 32'd0});
            chk("t1_tags", 64'({olog[k].s, olog[k].t}), 64'h1234);
        end
        repeat (4) tick();
        seq[0] = 0; seq[3] = 0; rem[0] = 1; rem[3] = 1;
        refresh();
        tick();
        chk("t1_rr_next", 64'(grant_id), 64'd3);
        repeat (8) tick();

        // all requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 16; seq[i] = 0; s_base[i] = 8'(i); d_base[i] = 8'(64 + i);
        end
        refresh();
        olog.delete();
        for (int n = 0; n < 300 && olog.size() < 64; n++) tick();
        chk("t2_count", 64'(olog.size()), 64'd64);
        errs = 0;
        for (int k = 0; k < olog.size(); k++) begin
            if (olog[k].d[63:56] != 8'((k / 4) % 4)) errs++;
        end
        chk("t2_order_errs", 64'(errs), 64'd0);
        if (olog.size() == 64) chk("t2_span", 64'(olog[63].cyc - olog[0].cyc), 64'd78);

        // backpressure mid-burst
        drain();
        rem[1] = 6; seq[1] = 0; s_base[1] = 8'h21; d_base[1] = 8'h43;
        refresh();
        olog.delete();
        for (int n = 0; n < 100 && olog.size() < 6; n++) begin
            d_otr = pat[n % 4][0];
            tick();
        end
        chk("t3_count", 64'(olog.size()), 64'd6);
        for (int k = 0; k < olog.size() && k < 6; k++) begin
            chk("t3_data", 64'(olog[k].d), {8'd1, 24'(k), 32'd0});
        end

        // tag change forces re-arbitration
        drain();
        rem[1] = 4; seq[1] = 0; s_base[1] = 8'h20; d_base[1] = 8'h05; d_alt[1] = 8'h06; sw[1] = 3;
        refresh();
        olog.delete();
        for (int n = 0; n < 60 && olog.size() < 4; n++) tick();
        chk("t4_count", 64'(olog.size()), 64'd4);
        for (int k = 0; k < olog.size() && k < 4; k++) begin
            chk("t4_dst", 64'(olog[k].t), (k < 3) ? 64'h05 : 64'h06);
        end
        if (olog.size() == 4) chk("t4_gap", 64'(olog[3].cyc - olog[2].cyc), 64'd3);
        sw[1] = BIG;

        // reset in the middle of a stalled burst
        drain();
        rem[1] = 2; seq[1] = 0;
        refresh();
        repeat (8) tick();
        rem[3] = 8; seq[3] = 0; d_otr = 1'b0;
        refresh();
        for (int n = 0; n < 20 && !bus.out_tvalid; n++) tick();
        chk("t5_stalled_beat", 64'(bus.out_tvalid), 64'd1);
        #2 arstn = 1'b0;
        #1;
        chk("t5_rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        chk("t5_rst_req_tready", 64'(bus.req_tready), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge aclk);
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; seq[i] = 0;
        end
        rem[0] = 1; rem[2] = 1; d_otr = 1'b1;
        refresh();
        arstn = 1'b1;
        tick();
        chk("t5_restart_grant", 64'(grant_id), 64'd0);
        repeat (8) tick();

        // randomized traffic against the model
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = BIG; seq[i] = 0; rv[i] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            rnd_inputs();
            tick();
        end
        rnd_mode = 0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        d_otr = 1'b1;
        refresh();
        repeat (10) tick();
`ifdef LII_OUT_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            chk("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_stat[i]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lii_out_arbiter.md
Name: lii_out_arbiter

Overview:
- Round-robin arbiter that shares one LII physical output channel (PW-bit data plus 8-bit src/dst tags) between NREQ logical requesters, such as several kernel wrappers' LII output ports.
- Grants are burst-locked: a grant is held for up to MAX_BURST beats so beats sharing one src/dst pair stay contiguous on the link.
- A single registered output stage sits between the arbiter and the phy.

Parameters:
- NREQ, 4, number of requesters (2..16).
- PW, 64, LII packing width.
- MAX_BURST, 16, maximum beats per grant (1..256).

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- req_tdata  in  NREQ*PW  requester data; requester i at [i*PW +: PW]
- req_tvalid  in  NREQ  per-requester valid
- req_tready  out  NREQ  per-requester ready
- req_src  in  NREQ*8  per-requester source tag, [i*8 +: 8]
- req_dst  in  NREQ*8  per-requester destination tag
- out_tdata  out  PW  phy data
- out_tvalid  out  1  phy valid
- out_tready  in  1  phy ready
- out_src  out  8  phy source tag
- out_dst  out  8  phy destination tag
- grant_id  out  clog2(NREQ)  currently or last granted requester
- busy  out  1  high in GRANT state

Behaviour:
- Reset (arstn low, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, out_tvalid=0, out_tdata/src/dst=0, req_tready=0. Reset mid-burst drops the registered beat. Release is synchronous to aclk.
- Output stage: single register. Load condition is `ld = ~out_tvalid | out_tready`.
  - When ld is true and a beat is accepted, the register loads the beat and sets out_tvalid=1.
  - When ld is true and no beat is accepted, out_tvalid clears.
  - When out_tvalid=1 and out_tready=0, data/src/dst are held stable (AXI-S rule).
- IDLE:
  - req_tready=0.
  - If any req_tvalid is set, g = first valid index scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - Next cycle: grant_id=g, tag_src/tag_dst latched from requester g, beat_cnt=0, state=GRANT.
  - Arbitration latency is 1 cycle; first data can be accepted the cycle after the request is seen.
- GRANT:
  - `req_tready[grant_id] = ld & tag_match`, where tag_match means requester g's src/dst equal the latched tags. All other req_tready bits are 0.
  - Accept = req_tvalid[g] & req_tready[g]. On accept, beat_cnt increments.
  - Release to IDLE, with rr_ptr=(g+1) mod NREQ, when any of:
    - (a) accept with beat_cnt==MAX_BURST-1;
    - (b) req_tvalid[g]=0 for one cycle (a bubble ends the burst);
    - (c) req_tvalid[g]=1 and tag_match=0. The mismatching beat is not accepted and is re-arbitrated later.
  - Rules (a)–(c) are evaluated only while ld=1. Backpressure (ld=0) holds GRANT indefinitely.
- Fairness: with all requesters continuously valid and tags constant, grants rotate 0,1,2,3,0… A requester waits at most (NREQ-1) × (MAX_BURST+1) accepted-or-idle cycles.
- Throughput: 1 beat/cycle within a burst when out_tready=1. There is 1 idle cycle per grant change.
- grant_id holds its value in IDLE. busy=(state==GRANT).
- Requester valids that drop without a handshake are tolerated; no beat is lost or duplicated.

Optional Feature:
- Macro: LII_OUT_ARBITER_STATS_EN.
- When defined, an added output port `stat_beats` (NREQ*32, out) carries one 32-bit counter per requester.
  - Each counter increments on every accepted beat of its requester and wraps at 2^32.
  - Counters reset to 0 on arstn.
- When undefined, the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single requester: req 2 sends 5 beats, tags src=0x12 dst=0x34, out_tready=1 → out shows the 5 beats in order with src/dst 0x12/0x34. First out_tvalid appears 2 cycles after req_tvalid rises. After the 5th beat the stalled bubble releases the grant, giving rr_ptr=3.
- All 4 requesters continuously valid, MAX_BURST=4, constant tags → output grant order 0,0,0,0,1,1,1,1,2…,3…,0. There is exactly 1 idle cycle between groups; no starvation over 64 beats.
- Backpressure: out_tready toggles 1,0,0,1 mid-burst → out_tdata stable while stalled, no beat lost/duplicated, beat_cnt advances only on accepts.
- Tag change: req 1 sends 3 beats dst=0x05 then a beat dst=0x06 → first 3 beats are forwarded, then the grant is released. The 4th beat is forwarded only after re-arbitration, with out_dst=0x06.
- Reset mid-burst: arstn low while out_tvalid=1 → out_tvalid=0, req_tready=0 immediately. After release, arbitration restarts from requester 0.
- Stats (LII_OUT_ARBITER_STATS_EN): 7 beats from req 0 and 3 from req 3 → stat_beats = {3,0,0,7}.
